// File: rtl/ped_request.sv
// Pedestrian pushbutton front end: synchronizer, debouncer and request FSM.
// Define PED_REQ_TIMEOUT_EN to drop requests left unserved for TIMEOUT cycles.
module ped_request #(
    parameter int unsigned DB_CYCLES = 4,
    parameter int unsigned TIMEOUT   = 200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_raw,
    input  logic       walk_on,
    output logic       btn,
    output logic [1:0] state,
    output logic [7:0] wait_cnt,
    output logic       tmo
);

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StPend    = 2'b01,
        StServe   = 2'b10,
        StHoldoff = 2'b11
    } state_e;

    localparam logic [3:0] DbLast = 4'(DB_CYCLES - 1);

    if (DB_CYCLES == 0 || DB_CYCLES > 15 || TIMEOUT == 0 || TIMEOUT > 255) begin : g_bad_param
        $error("ped_request: DB_CYCLES or TIMEOUT out of range");
    end

    logic       sync1;
    logic       key_s;
    logic [1:0] sync_vld;
    logic       key_db;
    logic [3:0] db_cnt;
    logic       armed;
    state_e     state_q;

    assign state = state_q;

    // sync_vld marks when key_s holds a real sample rather than its reset value
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1    <= 1'b0;
            key_s    <= 1'b0;
            sync_vld <= 2'b00;
        end else begin
            sync1    <= key_raw;
            key_s    <= sync1;
            sync_vld <= {sync_vld[0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_db <= 1'b0;
            db_cnt <= 4'd0;
        end else if (key_s == key_db) begin
            db_cnt <= 4'd0;
        end else if (db_cnt == DbLast) begin
            key_db <= ~key_db;
            db_cnt <= 4'd0;
        end else begin
            db_cnt <= db_cnt + 4'd1;
        end
    end

`ifdef PED_REQ_TIMEOUT_EN
    localparam logic [7:0] TmoLast = 8'(TIMEOUT - 1);
    logic tmo_q;
    assign tmo = tmo_q;
`else
    assign tmo = 1'b0;
`endif

    // A request is taken one edge after key_db rises, and only once the key has been
    // seen released since the last request or reset, so a held key never re-requests.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            btn      <= 1'b0;
            wait_cnt <= 8'd0;
            armed    <= 1'b0;
`ifdef PED_REQ_TIMEOUT_EN
            tmo_q    <= 1'b0;
`endif
        end else begin
`ifdef PED_REQ_TIMEOUT_EN
            tmo_q <= 1'b0;
`endif
            if (state_q == StIdle && key_db && armed) begin
                armed <= 1'b0;
            end else if (sync_vld[1] && !key_s && !key_db) begin
                armed <= 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    if (key_db && armed) begin
                        state_q  <= StPend;
                        btn      <= 1'b1;
                        wait_cnt <= 8'd0;
                    end
                end
                StPend: begin
                    if (walk_on) begin
                        state_q <= StServe;
                        btn     <= 1'b0;
                    end
`ifdef PED_REQ_TIMEOUT_EN
                    else if (wait_cnt == TmoLast) begin
                        state_q  <= StIdle;
                        btn      <= 1'b0;
                        wait_cnt <= 8'd0;
                        tmo_q    <= 1'b1;
                    end
`endif
                    else if (wait_cnt != 8'hff) begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                StServe: begin
                    if (!walk_on) begin
                        state_q <= StHoldoff;
                    end
                end
                StHoldoff: begin
                    if (!key_db) begin
                        state_q  <= StIdle;
                        wait_cnt <= 8'd0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ped_request.sv
// Randomized and directed bench for ped_request against a behavioural model.
module tb_ped_request;

    localparam int unsigned DB  = 4;
    localparam int unsigned TMO = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       key_raw = 1'b0;
    logic       walk_on = 1'b0;
    logic       btn;
    logic       tmo;
    logic [1:0] state;
    logic [7:0] wait_cnt;

    int nvec = 0;
    int nerr = 0;

    ped_request #(
        .DB_CYCLES(DB),
        .TIMEOUT  (TMO)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .key_raw (key_raw),
        .walk_on (walk_on),
        .btn     (btn),
        .state   (state),
        .wait_cnt(wait_cnt),
        .tmo     (tmo)
    );

    always #5 clk = ~clk;

    // Model state: sync pipeline, window of recent synced samples, accepted level,
    // request phase (0 idle, 1 pending, 2 serving, 3 hold-off).
    bit m_s1, m_s2, m_db, m_arm, m_tmo;
    bit hist[DB];
    int m_vld, m_st, m_wait;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_db = 0; m_arm = 0; m_tmo = 0;
        m_vld = 0; m_st = 0; m_wait = 0;
        for (int i = 0; i < DB; i++) hist[i] = 0;
    endtask

    task automatic model_edge();
        bit flip;
        bit take;
        take  = (m_st == 0) && m_db && m_arm;
        m_tmo = 0;
        // a released key (real sample) is required between requests
        if (take) m_arm = 0;
        else if (m_vld >= 2 && !m_s2 && !m_db) m_arm = 1;
        case (m_st)
            0: if (take) begin m_st = 1; m_wait = 0; end
            1: begin
                if (walk_on) m_st = 2;
`ifdef PED_REQ_TIMEOUT_EN
                else if (m_wait == int'(TMO) - 1) begin m_st = 0; m_wait = 0; m_tmo = 1; end
`endif
                else if (m_wait < 255) m_wait++;
            end
            2: if (!walk_on) m_st = 3;
            default: if (!m_db) begin m_st = 0; m_wait = 0; end
        endcase
        // accepted level flips once the last DB synced samples all disagree with it
        for (int i = DB - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = m_s2;
        flip = 1;
        for (int i = 0; i < DB; i++) if (hist[i] == m_db) flip = 0;
        if (flip) m_db = !m_db;
        m_s2 = m_s1;
        m_s1 = key_raw;
        if (m_vld < 2) m_vld++;
    endtask

    task automatic step();
        @(posedge clk);
        if (!reset) model_reset();
        else model_edge();
        @(negedge clk);
        check("state", state, m_st);
        check("btn", btn, m_st == 1);
        check("wait_cnt", wait_cnt, m_wait);
        check("tmo", tmo, m_tmo);
    endtask

    task automatic reset_pulse(input int cycles);
        #2 reset = 1'b0;
        model_reset();
        #1;
        check("rst_async_state", state, 0);
        check("rst_async_btn", btn, 0);
        check("rst_async_wait", wait_cnt, 0);
        repeat (cycles) step();
        #2 reset = 1'b1;
    endtask

    initial begin
        int n_btn, n_tmo, seg, wseg;
        bit lvl, hit;

        model_reset();
        #1;
        check("reset_state", state, 0);
        check("reset_btn", btn, 0);
        check("reset_wait", wait_cnt, 0);
        check("reset_tmo", tmo, 0);
        repeat (2) step();
        #2 reset = 1'b1;
        repeat (5) step();

        // Press latency: btn rises on edge 3+DB
        key_raw = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            step();
            if (e == 6) check("lat_btn_e6", btn, 0);
            if (e == 7) begin
                check("lat_btn_e7", btn, 1);
                check("lat_state_e7", state, 1);
                check("lat_wait_e7", wait_cnt, 0);
            end
            if (e == 9) check("lat_wait_e9", wait_cnt, 2);
        end

        // Serve with key held, then hold-off until release
        walk_on = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            step();
            check("serve_state", state, 2);
            check("serve_wait_hold", wait_cnt, 2);
        end
        walk_on = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            step();
            check("holdoff_state", state, 3);
            check("holdoff_btn", btn, 0);
        end
        key_raw = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            step();
            check("release_btn", btn, 0);
            if (e == 6) check("holdoff_e6", state, 3);
        end
        check("release_idle", state, 0);
        check("release_wait", wait_cnt, 0);

        // Bounce shorter than DB cycles
        key_raw = 1'b1;
        repeat (3) step();
        key_raw = 1'b0;
        for (int e = 1; e <= 15; e++) begin
            step();
            check("bounce_state", state, 0);
            check("bounce_btn", btn, 0);
        end

`ifdef PED_REQ_TIMEOUT_EN
        n_btn = 0;
        n_tmo = 0;
        key_raw = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            if (i == 6) key_raw = 1'b0;
            n_btn += int'(btn);
            n_tmo += int'(tmo);
        end
        check("tmo_btn_cycles", n_btn, TMO);
        check("tmo_pulses", n_tmo, 1);
        check("tmo_state", state, 0);

        // walk_on on the last pending cycle beats the timeout
        key_raw = 1'b1;
        repeat (7) step();
        key_raw = 1'b0;
        hit = 0;
        for (int i = 0; i < 30 && !hit; i++) begin
            step();
            if (wait_cnt == 8'(TMO - 1) && state == 2'b01) hit = 1;
        end
        check("tmo_race_reach", hit, 1);
        walk_on = 1'b1;
        step();
        check("tmo_race_state", state, 2);
        check("tmo_race_tmo", tmo, 0);
        walk_on = 1'b0;
        repeat (10) step();
        check("tmo_race_idle", state, 0);
`else
        n_tmo = 0;
        key_raw = 1'b1;
        repeat (7) step();
        key_raw = 1'b0;
        for (int i = 0; i < 300; i++) begin
            step();
            n_tmo += int'(tmo);
        end
        check("notmo_state", state, 1);
        check("notmo_wait_sat", wait_cnt, 255);
        check("notmo_pulses", n_tmo, 0);
        walk_on = 1'b1;
        step();
        walk_on = 1'b0;
        repeat (10) step();
        check("notmo_idle", state, 0);
`endif

        // Reset in PEND drops the request; held key must be released first
        key_raw = 1'b1;
        repeat (7) step();
        check("rst_pend", state, 1);
        reset_pulse(2);
        for (int e = 1; e <= 20; e++) begin
            step();
            check("rst_held_idle", state, 0);
        end
        key_raw = 1'b0;
        repeat (10) step();
        key_raw = 1'b1;
        repeat (7) step();
        check("rst_repress", state, 1);
        walk_on = 1'b1;
        step();
        walk_on = 1'b0;
        key_raw = 1'b0;
        repeat (12) step();

        // Random bouncy key, random walk_on, rare asynchronous resets
        seg = 0;
        wseg = 0;
        lvl = 0;
        for (int i = 0; i < 4000; i++) begin
            if (seg == 0) begin
                seg = int'($urandom_range(1, 30));
                lvl = bit'($urandom_range(0, 1));
            end
            seg--;
            key_raw = ($urandom_range(0, 7) == 0) ? !lvl : lvl;
            if (wseg == 0) begin
                wseg = int'($urandom_range(1, 60));
                walk_on = bit'($urandom_range(0, 1));
            end
            wseg--;
            if ($urandom_range(0, 799) == 0) reset_pulse(int'($urandom_range(1, 3)));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
